// File: rtl/lpm_pkg.sv
// lpm_pkg: shared table sizes, route-entry field positions and controller states.
package lpm_pkg;
    localparam int C_S_AXI_DATA_WIDTH = 32;
    localparam int ENTRY_WIDTH = 4 * C_S_AXI_DATA_WIDTH;
    localparam int NUM_ENTRIES = 32;
    localparam int IDX_WIDTH = 5;
    localparam int IP_HI = 127;
    localparam int IP_LO = 96;
    localparam int MASK_HI = 95;
    localparam int MASK_LO = 64;
    localparam int OQ_HI = 63;
    localparam int OQ_LO = 32;
    localparam int NH_HI = 31;
    localparam int NH_LO = 0;
    typedef enum logic [2:0] {IDLE, SCAN, DONE, WR, RD, CLR} state_t;
endpackage

// File: rtl/lpm_entry_match.sv
// lpm_entry_match: does one entry match the lookup IP, and does it beat the current best prefix.
module lpm_entry_match
    import lpm_pkg::*;
(
    input  logic [C_S_AXI_DATA_WIDTH-1:0] lkp_ip,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] ent_ip,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] ent_mask,
    input  logic                          ent_valid,
    input  logic                          best_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] best_mask,
    output logic                          better
);
    logic match;
    assign match = ent_valid && ((lkp_ip & ent_mask) == (ent_ip & ent_mask));
    // Strictly greater keeps the lower index on equal prefix lengths.
    assign better = match && (!best_valid || ent_mask > best_mask);
endmodule

// File: rtl/lpm_tbl_ctrl.sv
// lpm_tbl_ctrl: 32-entry LPM route table shared between host register access
// and a one-entry-per-cycle longest-prefix lookup scan.
module lpm_tbl_ctrl
    import lpm_pkg::*;
(
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESETN,
    input  logic                          tbl_wr_req,
    input  logic [IDX_WIDTH-1:0]          tbl_wr_addr,
    input  logic [ENTRY_WIDTH-1:0]        tbl_wr_data,
    output logic                          tbl_wr_ack,
    input  logic                          tbl_rd_req,
    input  logic [IDX_WIDTH-1:0]          tbl_rd_addr,
    output logic [ENTRY_WIDTH-1:0]        tbl_rd_data,
    output logic                          tbl_rd_ack,
    input  logic                          tbl_clear_req,
    output logic                          tbl_clear_ack,
    input  logic                          lkp_req,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] lkp_ip,
    output logic                          lkp_ack,
    output logic                          lkp_hit,
    output logic [IDX_WIDTH-1:0]          lkp_index,
    output logic [C_S_AXI_DATA_WIDTH-1:0] lkp_nh,
    output logic [C_S_AXI_DATA_WIDTH-1:0] lkp_oq,
    output logic                          lkp_busy,
    output logic [C_S_AXI_DATA_WIDTH-1:0] lpm_miss_count
);
    state_t state, next, host_op;
    logic [ENTRY_WIDTH-1:0] tbl [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid;
    logic wr_pend, rd_pend, clr_pend, host_pend, host_turn;
    logic [IDX_WIDTH-1:0] wr_addr_q, rd_addr_q, idx, best_idx, fin_idx;
    logic [ENTRY_WIDTH-1:0] wr_data_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] ip_q, best_mask;
    logic best_valid, better, last, fin_hit;

    lpm_entry_match u_match (
        .lkp_ip     (ip_q),
        .ent_ip     (tbl[idx][IP_HI:IP_LO]),
        .ent_mask   (tbl[idx][MASK_HI:MASK_LO]),
        .ent_valid  (valid[idx]),
        .best_valid (best_valid),
        .best_mask  (best_mask),
        .better     (better)
    );

    assign host_pend = clr_pend || wr_pend || rd_pend;
    assign host_op   = clr_pend ? CLR : wr_pend ? WR : RD;
    assign last      = (idx == IDX_WIDTH'(NUM_ENTRIES - 1));
    assign fin_hit   = better || best_valid;
    assign fin_idx   = better ? idx : best_idx;
    assign lkp_ack   = (state == DONE);
    assign lkp_busy  = (state == SCAN);

    // host_turn alternates service so neither requester starves under contention
    always_comb begin
        next = state;
        case (state)
            IDLE: next = (host_turn && host_pend) ? host_op : lkp_req ? SCAN : host_pend ? host_op : IDLE;
            SCAN: next = last ? DONE : SCAN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (state == WR)
            tbl[wr_addr_q] <= wr_data_q;
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state          <= IDLE;
            valid          <= '0;
            wr_pend        <= 1'b0;
            rd_pend        <= 1'b0;
            clr_pend       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_addr_q      <= '0;
            host_turn      <= 1'b0;
            ip_q           <= '0;
            idx            <= '0;
            best_valid     <= 1'b0;
            best_mask      <= '0;
            best_idx       <= '0;
            tbl_wr_ack     <= 1'b0;
            tbl_rd_ack     <= 1'b0;
            tbl_clear_ack  <= 1'b0;
            tbl_rd_data    <= '0;
            lkp_hit        <= 1'b0;
            lkp_index      <= '0;
            lkp_nh         <= '0;
            lkp_oq         <= '0;
            lpm_miss_count <= '0;
        end else begin
            state         <= next;
            tbl_wr_ack    <= (state == WR);
            tbl_rd_ack    <= (state == RD);
            tbl_clear_ack <= (state == CLR);
            if (tbl_wr_req && !wr_pend) begin
                wr_pend   <= 1'b1;
                wr_addr_q <= tbl_wr_addr;
                wr_data_q <= tbl_wr_data;
            end else if (state == WR)
                wr_pend <= 1'b0;
            if (tbl_rd_req && !rd_pend) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= tbl_rd_addr;
            end else if (state == RD)
                rd_pend <= 1'b0;
            if (tbl_clear_req && !clr_pend)
                clr_pend <= 1'b1;
            else if (state == CLR)
                clr_pend <= 1'b0;
            if (state == DONE)
                host_turn <= 1'b1;
            else if (state inside {WR, RD, CLR})
                host_turn <= 1'b0;
            if (state == WR)
                valid[wr_addr_q] <= 1'b1;
            if (state == CLR)
                valid <= '0;
            if (state == RD)
                tbl_rd_data <= tbl[rd_addr_q];
            if (state == IDLE && next == SCAN) begin
                ip_q       <= lkp_ip;
                idx        <= '0;
                best_valid <= 1'b0;
                best_mask  <= '0;
                best_idx   <= '0;
            end
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (better) begin
                    best_valid <= 1'b1;
                    best_mask  <= tbl[idx][MASK_HI:MASK_LO];
                    best_idx   <= idx;
                end
                if (last) begin
                    lkp_hit   <= fin_hit;
                    lkp_index <= fin_hit ? fin_idx : '0;
                    lkp_nh    <= fin_hit ? tbl[fin_idx][NH_HI:NH_LO] : '0;
                    lkp_oq    <= fin_hit ? tbl[fin_idx][OQ_HI:OQ_LO] : '0;
                    if (!fin_hit)
                        lpm_miss_count <= lpm_miss_count + 32'd1;
                end
            end
        end
    end
endmodule
